// File: rtl/mux_scanner_pkg.sv
// rtl/mux_scanner_pkg.sv - shared FSM state type and width helper for the mux scanner
package mux_scanner_pkg;

  typedef enum logic [1:0] {
    MANUAL = 2'd0,
    SCAN   = 2'd1,
    HOLD   = 2'd2
  } scan_state_t;

  function automatic int clog2(input int value);
    int result;
    int rem;
    result = 0;
    rem = value - 1;
    while (rem > 0) begin
      result = result + 1;
      rem = rem >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/mux_lane.sv
// rtl/mux_lane.sv - combinational NUM_IN:1 selector for one lane with forced-high inputs
module mux_lane
  import mux_scanner_pkg::*;
#(
  parameter int NUM_IN = 4,
  parameter logic [NUM_IN-1:0] FORCE_HI_MASK = 4'b1000,
  localparam int SEL_W = clog2(NUM_IN)
) (
  input  logic [NUM_IN-1:0] data,
  input  logic [SEL_W-1:0]  sel,
  output logic              y
);

  logic [NUM_IN-1:0] eff;

  // Masked positions read as constant 1 regardless of the lane's data.
  assign eff = data | FORCE_HI_MASK;
  assign y   = eff[sel];

endmodule

// File: rtl/mux_scanner.sv
// rtl/mux_scanner.sv - multi-lane mux with manual select, dwell-timed auto-scan and hold
module mux_scanner
  import mux_scanner_pkg::*;
#(
  parameter int NUM_IN = 4,
  parameter int NUM_LANES = 2,
  parameter int DWELL = 4,
  parameter logic [NUM_IN-1:0] FORCE_HI_MASK = 4'b1000,
  localparam int SEL_W = clog2(NUM_IN)
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_LANES*NUM_IN-1:0]    data_in,
  input  logic [SEL_W-1:0]               sel_in,
  input  logic                           sel_load,
  input  logic                           scan_en,
  input  logic                           hold,
  output logic [NUM_LANES-1:0]           data_out,
  output logic [SEL_W-1:0]               sel_out,
  output logic                           wrap
);

  localparam int CNT_W = (DWELL > 1) ? clog2(DWELL) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);
  localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(NUM_IN - 1);

  scan_state_t          state;
  scan_state_t          next_state;
  logic [CNT_W-1:0]     cnt;
  logic [CNT_W-1:0]     cnt_nxt;
  logic [SEL_W-1:0]     sel_nxt;
  logic [NUM_LANES-1:0] data_nxt;
  logic                 wrap_nxt;
  logic [NUM_LANES-1:0] lane_bit;

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    mux_lane #(
      .NUM_IN       (NUM_IN),
      .FORCE_HI_MASK(FORCE_HI_MASK)
    ) u_lane (
      .data(data_in[l*NUM_IN +: NUM_IN]),
      .sel (sel_out),
      .y   (lane_bit[l])
    );
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= MANUAL;
      sel_out  <= '0;
      cnt      <= '0;
      data_out <= '0;
      wrap     <= 1'b0;
    end else begin
      state    <= next_state;
      sel_out  <= sel_nxt;
      cnt      <= cnt_nxt;
      data_out <= data_nxt;
      wrap     <= wrap_nxt;
    end
  end

  // The mode for each edge comes from the inputs sampled at that edge, so
  // hold freezes and scan_en takes effect without an extra cycle of delay.
  always_comb begin
    next_state = MANUAL;
    sel_nxt    = sel_out;
    cnt_nxt    = cnt;
    data_nxt   = data_out;
    wrap_nxt   = 1'b0;

    if (hold) begin
      next_state = HOLD;
    end else if (scan_en) begin
      next_state = SCAN;
    end

    case (next_state)
      MANUAL: begin
        data_nxt = lane_bit;
        // Counter is already 0 if we stayed in MANUAL; clear it on entry.
        if (state != MANUAL) begin
          cnt_nxt = '0;
        end
        if (sel_load) begin
          sel_nxt = sel_in;
        end
      end
      SCAN: begin
        data_nxt = lane_bit;
        if (sel_load) begin
          sel_nxt = sel_in;
          cnt_nxt = '0;
        end else if (cnt == CNT_LAST) begin
          cnt_nxt  = '0;
          sel_nxt  = sel_out + SEL_W'(1);
          wrap_nxt = (sel_out == SEL_LAST);
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_mux_scanner.sv
// tb/tb_mux_scanner.sv - directed and randomized self-checking bench for mux_scanner
module tb_mux_scanner;
  import mux_scanner_pkg::*;

  localparam int NI = 4;
  localparam int NL = 2;
  localparam int DW = 4;
  localparam logic [NI-1:0] MASK = 4'b1000;

  logic       clk;
  logic       reset;
  logic [7:0] data_in;
  logic [1:0] sel_in;
  logic       sel_load;
  logic       scan_en;
  logic       hold;
  logic [1:0] data_out;
  logic [1:0] sel_out;
  logic       wrap;

  int checks = 0;
  int failures = 0;

  int         m_sel = 0;
  int         m_cnt = 0;
  logic [1:0] m_dout = '0;
  logic       m_wrap = 1'b0;

  mux_scanner #(
    .NUM_IN       (NI),
    .NUM_LANES    (NL),
    .DWELL        (DW),
    .FORCE_HI_MASK(MASK)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .data_in (data_in),
    .sel_in  (sel_in),
    .sel_load(sel_load),
    .scan_en (scan_en),
    .hold    (hold),
    .data_out(data_out),
    .sel_out (sel_out),
    .wrap    (wrap)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input int act, input int exp);
    checks = checks + 1;
    if (act != exp) begin
      failures = failures + 1;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: each edge picks its mode from hold/scan_en, then applies the
  // select, dwell and wrap rules directly on integers.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_sel  = 0;
      m_cnt  = 0;
      m_dout = '0;
      m_wrap = 1'b0;
    end else begin
      m_wrap = 1'b0;
      if (!hold) begin
        for (int l = 0; l < NL; l++) begin
          m_dout[l] = MASK[m_sel] ? 1'b1 : data_in[l*NI + m_sel];
        end
        if (sel_load) begin
          m_sel = int'(sel_in);
          m_cnt = 0;
        end else if (!scan_en) begin
          m_cnt = 0;
        end else if (m_cnt == DW - 1) begin
          m_cnt  = 0;
          m_wrap = (m_sel == NI - 1);
          m_sel  = (m_sel + 1) % NI;
        end else begin
          m_cnt = m_cnt + 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("model_sel_out", int'(sel_out), m_sel);
    chk("model_data_out", int'(data_out), int'(m_dout));
    chk("model_wrap", int'(wrap), int'(m_wrap));
  end

  task automatic edge1();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    edge1();
    reset = 1'b0;
  endtask

  initial begin
    logic [1:0] frozen;
    int wraps;
    reset    = 1'b1;
    data_in  = '0;
    sel_in   = '0;
    sel_load = 1'b0;
    scan_en  = 1'b0;
    hold     = 1'b0;
    edge1();
    edge1();
    chk("reset_sel_out", int'(sel_out), 0);
    chk("reset_data_out", int'(data_out), 0);
    chk("reset_wrap", int'(wrap), 0);
    reset = 1'b0;

    // manual select with latency
    data_in  = 8'b0110_0101;
    sel_in   = 2'd2;
    sel_load = 1'b1;
    edge1();
    chk("manual_sel_out", int'(sel_out), 2);
    chk("manual_dout_old_sel", int'(data_out), 1);
    sel_load = 1'b0;
    edge1();
    chk("manual_dout_sel2", int'(data_out), 3);
    data_in  = 8'h00;
    sel_in   = 2'd3;
    sel_load = 1'b1;
    edge1();
    chk("manual_sel3", int'(sel_out), 3);
    sel_load = 1'b0;
    edge1();
    chk("forced_dout", int'(data_out), 3);

    // scan and wrap
    do_reset();
    data_in = 8'h5A;
    scan_en = 1'b1;
    wraps   = 0;
    for (int e = 1; e <= 20; e++) begin
      edge1();
      chk("scan_sel_seq", int'(sel_out), (e / DW) % NI);
      chk("scan_wrap_at", int'(wrap), (e == 16) ? 1 : 0);
      wraps = wraps + int'(wrap);
    end
    chk("scan_wrap_count", wraps, 1);

    // hold during scan at sel_out=1, counter=2
    do_reset();
    data_in = 8'hA5;
    scan_en = 1'b1;
    repeat (6) edge1();
    chk("pre_hold_sel", int'(sel_out), 1);
    chk("pre_hold_cnt", int'(dut.cnt), 2);
    frozen = data_out;
    hold = 1'b1;
    for (int k = 0; k < 10; k++) begin
      data_in  = 8'($urandom);
      sel_load = (k == 4);
      edge1();
      chk("hold_sel", int'(sel_out), 1);
      chk("hold_dout", int'(data_out), int'(frozen));
      chk("hold_wrap", int'(wrap), 0);
    end
    sel_load = 1'b0;
    hold = 1'b0;
    edge1();
    chk("resume_edge1_sel", int'(sel_out), 1);
    edge1();
    chk("resume_edge2_sel", int'(sel_out), 2);

    // load at the dwell terminal beats the wrap
    do_reset();
    scan_en = 1'b1;
    repeat (15) edge1();
    chk("term_sel", int'(sel_out), 3);
    chk("term_cnt", int'(dut.cnt), 3);
    sel_in   = 2'd1;
    sel_load = 1'b1;
    edge1();
    sel_load = 1'b0;
    chk("load_term_sel", int'(sel_out), 1);
    chk("load_term_cnt", int'(dut.cnt), 0);
    chk("load_term_wrap", int'(wrap), 0);

    // asynchronous reset mid-scan
    do_reset();
    data_in = 8'hFF;
    scan_en = 1'b1;
    repeat (8) edge1();
    chk("mid_sel", int'(sel_out), 2);
    chk("mid_dout", int'(data_out), 3);
    #2;
    reset = 1'b1;
    #1;
    chk("async_sel", int'(sel_out), 0);
    chk("async_dout", int'(data_out), 0);
    chk("async_wrap", int'(wrap), 0);
    @(negedge clk);
    reset   = 1'b0;
    scan_en = 1'b0;
    edge1();
    chk("post_reset_state", int'(dut.state), int'(MANUAL));
    chk("post_reset_sel", int'(sel_out), 0);

    // randomized run against the reference
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      data_in  = 8'($urandom);
      sel_in   = 2'($urandom_range(0, 3));
      sel_load = ($urandom_range(0, 5) == 0);
      hold     = ($urandom_range(0, 6) == 0);
      if ($urandom_range(0, 15) == 0) scan_en = ~scan_en;
      if (reset) begin
        #2 reset = 1'b0;
      end else if ($urandom_range(0, 199) == 0) begin
        #2 reset = 1'b1;
      end
    end
    @(negedge clk);
    reset = 1'b0;
    hold  = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
